// File: rtl/krnl_partialknn_uram_arbiter.sv
// Round-robin arbiter for one single-port URAM bank shared by a tile loader
// (write port W) and two distance workers (read ports R0, R1). Requests are
// serialised onto the memory port, read data is tracked through a
// latency-matched valid/tag pipe, and responses are returned in issue order
// through a small credit-protected FIFO whose head is routed by tag.
module krnl_partialknn_uram_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int MEM_LATENCY  = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // write requester
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [AddressWidth-1:0] w_addr,
  input  logic [DataWidth-1:0]    w_data,
  // read requesters
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic [AddressWidth-1:0] r0_addr,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic [AddressWidth-1:0] r1_addr,
  // read responses (shared data bus, per-port valid)
  output logic                    r0_rsp_valid,
  input  logic                    r0_rsp_ready,
  output logic                    r1_rsp_valid,
  input  logic                    r1_rsp_ready,
  output logic [DataWidth-1:0]    rsp_data,
  // memory port
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0,
  output logic                    busy
);

  localparam int PtrWidth = $clog2(RSP_DEPTH);
  localparam int CntWidth = PtrWidth + 1;
  localparam logic [CntWidth:0] DepthVal = (CntWidth + 1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    PORT_W  = 2'd0,
    PORT_R0 = 2'd1,
    PORT_R1 = 2'd2
  } port_e;

  // Round-robin order W -> R0 -> R1 -> W
  function automatic port_e port_after(port_e p);
    case (p)
      PORT_W:  return PORT_R0;
      PORT_R0: return PORT_R1;
      default: return PORT_W;
    endcase
  endfunction

  // arbitration
  port_e last_q, last_d;
  port_e grant_port, cand;
  logic  grant_any, cand_ok, credit_ok, read_grant;
  logic [CntWidth:0] credit_sum;

  // memory issue register
  logic                    ce_q, ce_d;
  logic                    we_q, we_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic                    issue_tag_q, issue_tag_d;

  // read latency pipe
  logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [MEM_LATENCY-1:0] pipe_tag_q, pipe_tag_d;
  logic                   push, push_tag;

  // response FIFO and credit counters
  logic [CntWidth-1:0]  inflight_q, inflight_d;
  logic [CntWidth-1:0]  fifo_count_q, fifo_count_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [RSP_DEPTH-1:0] fifo_tag_q, fifo_tag_d;
  logic [DataWidth-1:0] fifo_data_mem [RSP_DEPTH];
  logic                 fifo_empty, head_tag, pop;

  // Credit uses registered counts only, so a pop frees a slot one cycle later
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign credit_ok  = (credit_sum < DepthVal);

  // Pick the first eligible port starting after the last-granted one
  always_comb begin
    grant_any  = 1'b0;
    grant_port = PORT_W;
    cand_ok    = 1'b0;
    cand       = port_after(last_q);
    for (int k = 0; k < 3; k++) begin
      case (cand)
        PORT_W:  cand_ok = w_valid;
        PORT_R0: cand_ok = r0_valid && credit_ok;
        default: cand_ok = r1_valid && credit_ok;
      endcase
      if (!reset && !grant_any && cand_ok) begin
        grant_any  = 1'b1;
        grant_port = cand;
      end
      cand = port_after(cand);
    end
    last_d = grant_any ? grant_port : last_q;
  end

  assign w_ready    = grant_any && (grant_port == PORT_W);
  assign r0_ready   = grant_any && (grant_port == PORT_R0);
  assign r1_ready   = grant_any && (grant_port == PORT_R1);
  assign read_grant = r0_ready || r1_ready;

  // Register the granted request onto the memory port; address/data hold when idle
  always_comb begin
    ce_d        = grant_any;
    we_d        = w_ready;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_tag_d = issue_tag_q;
    if (grant_any) begin
      case (grant_port)
        PORT_W: begin
          addr_d  = w_addr;
          wdata_d = w_data;
        end
        PORT_R0: begin
          addr_d      = r0_addr;
          issue_tag_d = 1'b0;
        end
        default: begin
          addr_d      = r1_addr;
          issue_tag_d = 1'b1;
        end
      endcase
    end
  end

  // Valid/tag shift pipe aligned so its output coincides with valid mem_q0
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_tag_d    = pipe_tag_q;
    pipe_vld_d[0] = ce_q && !we_q;
    pipe_tag_d[0] = issue_tag_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  assign push     = pipe_vld_q[MEM_LATENCY-1];
  assign push_tag = pipe_tag_q[MEM_LATENCY-1];

  assign fifo_empty   = (fifo_count_q == '0);
  assign head_tag     = fifo_tag_q[rd_ptr_q];
  assign r0_rsp_valid = !fifo_empty && !head_tag;
  assign r1_rsp_valid = !fifo_empty && head_tag;
  assign pop          = (r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready);
  assign rsp_data     = fifo_empty ? '0 : fifo_data_mem[rd_ptr_q];
  assign busy         = (inflight_q != '0) || !fifo_empty;

  // FIFO pointers, tags and occupancy; in-flight count spans accept to push
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
    fifo_tag_d   = fifo_tag_q;
    if (push) fifo_tag_d[wr_ptr_q] = push_tag;
    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CntWidth'(1);
      2'b01:   fifo_count_d = fifo_count_q - CntWidth'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
    inflight_d = inflight_q;
    case ({read_grant, push})
      2'b10:   inflight_d = inflight_q + CntWidth'(1);
      2'b01:   inflight_d = inflight_q - CntWidth'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset discards in-flight reads and queued responses
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q       <= PORT_R1;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      issue_tag_q  <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_tag_q   <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_tag_q   <= '0;
    end else begin
      last_q       <= last_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      issue_tag_q  <= issue_tag_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_tag_q   <= pipe_tag_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_tag_q   <= fifo_tag_d;
    end
  end

  // Response data storage; contents are only meaningful below fifo_count
  always_ff @(posedge clk) begin
    if (push) fifo_data_mem[wr_ptr_q] <= mem_q0;
  end

  assign mem_ce0      = ce_q;
  assign mem_we0      = we_q;
  assign mem_address0 = addr_q;
  assign mem_d0       = wdata_q;

endmodule

// File: tb/tb_krnl_partialknn_uram_arbiter.sv
// Bench for krnl_partialknn_uram_arbiter: a default build (latency 1) with a
// URAM model, plus a latency-3 build with a pattern-only read model.
module tb_krnl_partialknn_uram_arbiter;
  localparam int DW = 256;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // default build
  logic w_valid, w_ready, r0_valid, r0_ready, r1_valid, r1_ready;
  logic [AW-1:0] w_addr, r0_addr, r1_addr, mem_address0;
  logic [DW-1:0] w_data, rsp_data, mem_d0, mem_q0;
  logic r0_rsp_valid, r0_rsp_ready, r1_rsp_valid, r1_rsp_ready;
  logic mem_ce0, mem_we0, busy;

  // latency-3 build
  logic l3_r0_valid, l3_r0_ready, l3_w_ready, l3_r1_ready;
  logic [AW-1:0] l3_r0_addr, l3_mem_address0;
  logic [DW-1:0] l3_rsp_data, l3_mem_d0, l3_mem_q0, l3_s1, l3_s2;
  logic l3_r0_rsp_valid, l3_r1_rsp_valid, l3_mem_ce0, l3_mem_we0, l3_busy;

  krnl_partialknn_uram_arbiter u0 (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .rsp_data(rsp_data), .mem_address0(mem_address0), .mem_ce0(mem_ce0),
    .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0), .busy(busy)
  );

  krnl_partialknn_uram_arbiter #(.MEM_LATENCY(3)) u1 (
    .clk(clk), .reset(reset),
    .w_valid(1'b0), .w_ready(l3_w_ready), .w_addr('0), .w_data('0),
    .r0_valid(l3_r0_valid), .r0_ready(l3_r0_ready), .r0_addr(l3_r0_addr),
    .r1_valid(1'b0), .r1_ready(l3_r1_ready), .r1_addr('0),
    .r0_rsp_valid(l3_r0_rsp_valid), .r0_rsp_ready(1'b1),
    .r1_rsp_valid(l3_r1_rsp_valid), .r1_rsp_ready(1'b1),
    .rsp_data(l3_rsp_data), .mem_address0(l3_mem_address0), .mem_ce0(l3_mem_ce0),
    .mem_we0(l3_mem_we0), .mem_d0(l3_mem_d0), .mem_q0(l3_mem_q0), .busy(l3_busy)
  );

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a);
    return {8{32'hC0DE_0000 | 32'(a)}};
  endfunction

  function automatic logic [DW-1:0] l3pat(logic [AW-1:0] a);
    return {8{32'h3333_0000 | 32'(a)}};
  endfunction

  // URAM model, latency 1; unwritten words read as pat(addr)
  logic [DW-1:0] mem [2048];
  bit            written [2048];
  always @(posedge clk) begin
    if (mem_ce0) begin
      if (mem_we0) begin
        mem[mem_address0]     <= mem_d0;
        written[mem_address0] <= 1'b1;
      end else begin
        mem_q0 <= written[mem_address0] ? mem[mem_address0] : pat(mem_address0);
      end
    end
  end

  // Read-only model for the latency-3 build
  always @(posedge clk) begin
    if (l3_mem_ce0 && !l3_mem_we0) l3_s1 <= l3pat(l3_mem_address0);
    l3_s2     <= l3_s1;
    l3_mem_q0 <= l3_s2;
  end

  // Bench-side expected memory contents
  logic [DW-1:0] shadow [2048];
  bit            sh_written [2048];
  function automatic logic [DW-1:0] exp_read(logic [AW-1:0] a);
    return sh_written[a] ? shadow[a] : pat(a);
  endfunction

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q_main[$];
  exp_t q_l3[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected response whenever a response is handed off
  always @(negedge clk) begin
    if (!reset && ((r0_rsp_valid && r0_rsp_ready) || (r1_rsp_valid && r1_rsp_ready))) begin
      if (q_main.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got port r1=%0d data %h expected none", r1_rsp_valid, rsp_data);
      end else begin
        mon_e = q_main.pop_front();
        $display("rsp port=R%0d data=%h", r1_rsp_valid, rsp_data);
        check_int("rsp_port", int'(r1_rsp_valid), int'(mon_e.port));
        check_vec("rsp_data", rsp_data, mon_e.data);
      end
    end
    if (!reset && (l3_r0_rsp_valid || l3_r1_rsp_valid)) begin
      if (q_l3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l3_unexpected_rsp: got data %h expected none", l3_rsp_data);
      end else begin
        mon_e = q_l3.pop_front();
        $display("l3 rsp port=R%0d data=%h", l3_r1_rsp_valid, l3_rsp_data);
        check_int("l3_rsp_port", int'(l3_r1_rsp_valid), int'(mon_e.port));
        check_vec("l3_rsp_data", l3_rsp_data, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    w_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; l3_r0_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    q_main.delete();
    q_l3.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while ((q_main.size() != 0 || q_l3.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_int(name, q_main.size() + q_l3.size(), 0);
  endtask

  task automatic shadow_write(logic [AW-1:0] a, logic [DW-1:0] d);
    shadow[a]     = d;
    sh_written[a] = 1'b1;
    $display("write addr=%0d data=%h", a, d);
  endtask

  int k;
  int exp_g;
  int n;

  initial begin
    reset = 1'b1;
    idle_inputs();
    w_addr = '0; w_data = '0; r0_addr = '0; r1_addr = '0; l3_r0_addr = '0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    step();
    step();

    // Reset state
    at_neg();
    check_int("rst_ready", int'({w_ready, r0_ready, r1_ready}), 0);
    check_int("rst_rsp_valid", int'({r0_rsp_valid, r1_rsp_valid}), 0);
    check_int("rst_ce_we", int'({mem_ce0, mem_we0}), 0);
    check_int("rst_addr", int'(mem_address0), 0);
    check_vec("rst_d0", mem_d0, '0);
    check_vec("rst_rsp_data", rsp_data, '0);
    check_int("rst_busy", int'({busy, l3_busy}), 0);
    step();
    reset = 1'b0;

    // Write A5.. to address 5, then R0 reads it back-to-back
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    w_valid = 1'b1; w_addr = 11'd5; w_data = {32{8'hA5}};
    at_neg();
    check_int("t1_w_ready", int'(w_ready), 1);
    shadow_write(w_addr, w_data);
    step();
    w_valid = 1'b0; r0_valid = 1'b1; r0_addr = 11'd5;
    at_neg();
    check_int("t1_ce_we_write", int'({mem_ce0, mem_we0}), 3);
    check_int("t1_addr", int'(mem_address0), 5);
    check_vec("t1_d0", mem_d0, {32{8'hA5}});
    check_int("t1_r0_ready", int'(r0_ready), 1);
    q_main.push_back('{port: 1'b0, data: {32{8'hA5}}});
    step();
    r0_valid = 1'b0;
    at_neg();
    check_int("t1_ce_we_read", int'({mem_ce0, mem_we0}), 2);
    check_int("t1_busy", int'(busy), 1);
    step();
    at_neg();
    check_int("t1_rsp_early", int'(r0_rsp_valid), 0);
    step();
    at_neg();
    check_int("t1_rsp_valid", int'(r0_rsp_valid), 1);
    step();
    at_neg();
    check_int("t1_busy_done", int'(busy), 0);
    step();

    // All three held valid: rotation W, R0, R1 from reset
    do_reset();
    for (int i = 0; i < 30; i++) begin
      w_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
      w_addr  = AW'(100 + i);
      w_data  = {8{32'hD000_0000 + 32'(i)}};
      r0_addr = AW'(100 + i - 1);
      r1_addr = AW'(300 + i);
      at_neg();
      exp_g = 4 >> (i % 3);
      check_int("t2_grant", int'({w_ready, r0_ready, r1_ready}), exp_g);
      if (w_ready) shadow_write(w_addr, w_data);
      if (r0_ready) q_main.push_back('{port: 1'b0, data: exp_read(r0_addr)});
      if (r1_ready) q_main.push_back('{port: 1'b1, data: exp_read(r1_addr)});
      step();
    end
    idle_inputs();
    drain("t2_drain", 40);

    // R0 streams addresses 0..9 while its response port is stalled
    r0_rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      r0_valid = 1'b1; r0_addr = AW'(k);
      at_neg();
      if (r0_ready) begin
        q_main.push_back('{port: 1'b0, data: exp_read(r0_addr)});
        k++;
      end
      step();
    end
    check_int("t3_accepted_stalled", k, 4);
    r0_addr = AW'(k);
    at_neg();
    check_int("t3_ready_stalled", int'(r0_ready), 0);
    step();
    r0_rsp_ready = 1'b1;
    at_neg();
    check_int("t3_ready_pop_cycle", int'(r0_ready), 0);
    step();
    at_neg();
    check_int("t3_ready_after_pop", int'(r0_ready), 1);
    if (r0_ready) begin
      q_main.push_back('{port: 1'b0, data: exp_read(r0_addr)});
      k++;
    end
    step();
    n = 0;
    while (k < 10 && n < 80) begin
      r0_addr = AW'(k);
      at_neg();
      if (r0_ready) begin
        q_main.push_back('{port: 1'b0, data: exp_read(r0_addr)});
        k++;
      end
      step();
      n++;
    end
    check_int("t3_all_accepted", k, 10);
    idle_inputs();
    drain("t3_drain", 40);

    // R0 head blocks R1's response until it pops
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_addr = 11'd1;
    at_neg();
    check_int("t4_r0_ready", int'(r0_ready), 1);
    q_main.push_back('{port: 1'b0, data: exp_read(11'd1)});
    step();
    r0_valid = 1'b0; r1_valid = 1'b1; r1_addr = 11'd2;
    at_neg();
    check_int("t4_r1_ready", int'(r1_ready), 1);
    q_main.push_back('{port: 1'b1, data: exp_read(11'd2)});
    step();
    r1_valid = 1'b0;
    repeat (6) step();
    at_neg();
    check_int("t4_head_blocked", int'({r0_rsp_valid, r1_rsp_valid}), 2);
    check_int("t4_queue_held", q_main.size(), 2);
    step();
    r0_rsp_ready = 1'b1;
    at_neg();
    step();
    at_neg();
    check_int("t4_r1_after_pop", int'(r1_rsp_valid), 1);
    step();
    drain("t4_drain", 10);

    // Reset one cycle after two reads are accepted
    r0_valid = 1'b1; r0_addr = 11'd3;
    at_neg();
    check_int("t6_r0_ready", int'(r0_ready), 1);
    step();
    r0_valid = 1'b0; r1_valid = 1'b1; r1_addr = 11'd4;
    at_neg();
    check_int("t6_r1_ready", int'(r1_ready), 1);
    step();
    r1_valid = 1'b0;
    reset = 1'b1;
    q_main.delete();
    step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      at_neg();
      check_int("t6_no_rsp", int'({r0_rsp_valid, r1_rsp_valid}), 0);
      check_int("t6_busy", int'(busy), 0);
      step();
    end
    w_valid = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    w_addr = 11'd7; w_data = {8{32'h0BAD_F00D}}; r0_addr = 11'd8; r1_addr = 11'd9;
    at_neg();
    check_int("t6_w_first", int'({w_ready, r0_ready, r1_ready}), 4);
    if (w_ready) shadow_write(w_addr, w_data);
    step();
    idle_inputs();

    // Latency-3 build: rsp_valid at t+5, busy from t+1 until the pop
    l3_r0_valid = 1'b1; l3_r0_addr = 11'd9;
    at_neg();
    check_int("t5_ready", int'(l3_r0_ready), 1);
    q_l3.push_back('{port: 1'b0, data: l3pat(11'd9)});
    step();
    l3_r0_valid = 1'b0;
    for (int d = 1; d <= 5; d++) begin
      at_neg();
      check_int("t5_busy", int'(l3_busy), 1);
      check_int("t5_rsp_valid", int'(l3_r0_rsp_valid), (d == 5) ? 1 : 0);
      step();
    end
    at_neg();
    check_int("t5_busy_done", int'(l3_busy), 0);
    step();
    drain("final_drain", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/krnl_partialknn_uram_arbiter.md
# krnl_partialknn_uram_arbiter

Round-robin arbiter and sequencer sharing one single-port 256-bit × 2048 URAM bank of a partialKnn wrapper among one write requester (tile loader) and two read requesters (distance workers). It serialises requests onto the memory's address0/ce0/we0/d0 port, tracks read latency, and returns q0 data through a credit-protected response FIFO. Each read response is routed back to the read port that issued it.

## Interface
- DataWidth, 256, memory word width
- AddressWidth, 11, memory address width (AddressRange 2048)
- MEM_LATENCY, 1, cycles from the mem_ce0 read cycle to valid mem_q0 (1..4)
- RSP_DEPTH, 4, shared response FIFO depth (power of 2, ≥ MEM_LATENCY+1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- w_valid / w_ready  in/out  1  write request handshake
- w_addr  in  AddressWidth  write address
- w_data  in  DataWidth  write data
- r0_valid / r0_ready, r1_valid / r1_ready  in/out  1  read request handshakes
- r0_addr, r1_addr  in  AddressWidth  read addresses
- r0_rsp_valid / r0_rsp_ready, r1_rsp_valid / r1_rsp_ready  out/in  1  read response handshakes
- rsp_data  out  DataWidth  FIFO head data, shared by both response ports
- mem_address0  out  AddressWidth  memory address
- mem_ce0, mem_we0  out  1  memory enable and write enable
- mem_d0  out  DataWidth  memory write data
- mem_q0  in  DataWidth  memory read data
- busy  out  1  any read in flight or FIFO non-empty

## Operation
- Port order is W, R0, R1. A 2-bit last-grant pointer resets to R1, so W has first priority after reset.
- Each cycle, at most one eligible requester is granted. The search starts at the port after the last-granted port. The pointer updates only on a grant.
- W is eligible when w_valid=1. Rn is eligible when rn_valid=1 and credit is available.
- Credit is available when reads_in_flight + fifo_count < RSP_DEPTH.
- The ready signals are combinational. A ready is asserted only for the granted port. A request is accepted on valid&ready.
- Accepted request: on the next cycle, mem_ce0=1 and the address is registered. For a write, mem_we0=1 and mem_d0 carries the write data. For a read, mem_we0=0.
- Idle cycles: mem_ce0=0, mem_we0=0. Address and data hold their last values.
- Each issued read pushes a 1-bit tag (0=R0, 1=R1) into a MEM_LATENCY-stage valid/tag shift pipe.
- When the pipe output is valid, mem_q0 and the tag are written into the FIFO. Credit guarantees the FIFO is never full on a push.
- FIFO head: r0_rsp_valid=1 when tag=0, r1_rsp_valid=1 when tag=1. Pop on the matching rsp_ready.
- Responses are strictly in issue order. Head-of-line blocking across readers is intended.
- Memory ordering equals grant order. A read granted after a write to the same address returns the new data.
- A FIFO push and pop in the same cycle leaves fifo_count unchanged.

## Timing
- Reset values: all ready/valid outputs 0, mem_ce0=0, mem_we0=0, mem_address0=0, mem_d0=0, rsp_data=0, busy=0.
- Reset values, internal state: FIFO empty, pipe cleared, pointer=R1.
- Reset mid-operation discards all in-flight reads and FIFO contents. No response appears after reset. The memory contents are untouched.
- Read accepted at cycle t: mem_ce0 asserts at t+1, mem_q0 is valid at t+1+MEM_LATENCY, rsp_valid rises at t+2+MEM_LATENCY.
- With defaults, read latency is 3 cycles from accept to rsp_valid.
- Write accepted at t is committed at t+1.
- Throughput is one request per cycle. Sustained reads are limited only by credit.
- A credit is freed by a pop in cycle c and is usable for a grant in cycle c+1, because credit uses registered counts.

## Test plan
- Reset, then W writes 0xA5..A5 at address 5 and R0 reads address 5 back-to-back: mem_we0=1 at t+1, mem_we0=0 at t+2; r0_rsp_valid at t+4 with rsp_data 0xA5..A5.
- W, R0 and R1 all held valid with credit available: grants rotate W, R0, R1, W, …, one per cycle, with no starvation over 30 cycles.
- R0 streams reads at addresses 0..9 with r0_rsp_ready=0: exactly 4 accepted, r0_ready=0 while stalled, no FIFO overflow. Releasing ready returns data for addresses 0..9 in order.
- Interleaved R0 read of address 1 and R1 read of address 2, with r1_rsp_ready=1 and r0_rsp_ready=0: R1's response is blocked until the R0 head pops; tags route data correctly.
- MEM_LATENCY=3 build: a read accepted at t gives rsp_valid at t+5; busy=1 from t+1 until the pop.
- reset asserted one cycle after two reads are accepted: no rsp_valid afterwards, busy=0, and the next write is granted to W first.
